// File: rtl/time_pkg.sv
// rtl/time_pkg.sv - shared types, limits and hand-tick helper for the time keeper
package time_pkg;

  localparam logic [5:0] SEC_MAX   = 6'd59;
  localparam logic [5:0] MIN_MAX   = 6'd59;
  localparam logic [4:0] HOUR_MAX  = 5'd23;
  localparam logic [3:0] MONTH_MAX = 4'd12;

  typedef enum logic {
    UNSET = 1'b0,
    RUN   = 1'b1
  } tk_state_t;

  typedef struct packed {
    logic [4:0] hour;
    logic [5:0] minute;
    logic [5:0] second;
    logic [3:0] month;
    logic [4:0] day;
    logic [5:0] year;
  } tk_time_t;

  localparam tk_time_t TK_RESET = '{hour: 5'd0, minute: 6'd0, second: 6'd0,
                                    month: 4'd1, day: 5'd1, year: 6'd0};

  // Hour hand position on the 60-tick dial: (hour%12)*5 + minute/12, max 59.
  function automatic logic [5:0] hand_tick(input logic [4:0] hour, input logic [5:0] minute);
    logic [5:0] h12;
    h12 = (hour >= 5'd12) ? {1'b0, hour - 5'd12} : {1'b0, hour};
    return (h12 * 6'd5) + (minute / 6'd12);
  endfunction

endpackage

// File: rtl/month_days.sv
// rtl/month_days.sv - days in a month for a year counted from 2000
module month_days (
  input  logic [3:0] month,
  input  logic [5:0] year,
  output logic [4:0] days
);

  always_comb begin
    days = 5'd31;
    case (month)
      4'd2:                   days = (year[1:0] == 2'b00) ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11: days = 5'd30;
      default:                days = 5'd31;
    endcase
  end

endmodule

// File: rtl/time_keeper.sv
// rtl/time_keeper.sv - free-running clock/calendar with SPI realignment and frame-synchronous display shadow
module time_keeper
  import time_pkg::*;
#(
  parameter int CLK_HZ = 40_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_valid,
  input  logic [4:0] load_hour,
  input  logic [5:0] load_minute,
  input  logic [5:0] load_second,
  input  logic [3:0] load_month,
  input  logic [4:0] load_day,
  input  logic [5:0] load_year,
  input  logic       frame_start,
  output logic       sec_tick,
  output logic       time_valid,
  output logic       load_err,
  output logic [5:0] disp_second,
  output logic [5:0] disp_minute,
  output logic [5:0] disp_hour,
  output logic [3:0] disp_month,
  output logic [4:0] disp_day,
  output logic [5:0] disp_year
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);

  logic [PW-1:0] presc_q;
  tk_time_t      cur_q;
  tk_time_t      cur_inc;
  tk_time_t      load_t;
  tk_state_t     state_q;
  tk_state_t     state_d;
  logic [4:0]    cur_dim;
  logic [4:0]    load_dim;
  logic          load_ok;
  logic          accept;

  month_days u_days_cur (
    .month (cur_q.month),
    .year  (cur_q.year),
    .days  (cur_dim)
  );

  month_days u_days_load (
    .month (load_month),
    .year  (load_year),
    .days  (load_dim)
  );

  assign sec_tick   = (presc_q == PRESC_LAST);
  assign time_valid = (state_q == RUN);

  assign load_t = '{hour: load_hour, minute: load_minute, second: load_second,
                    month: load_month, day: load_day, year: load_year};

  // Day is checked against the frame's own month/year, not the running calendar.
  assign load_ok = (load_hour <= HOUR_MAX) && (load_minute <= MIN_MAX) &&
                   (load_second <= SEC_MAX) && (load_month != 4'd0) &&
                   (load_month <= MONTH_MAX) && (load_day != 5'd0) &&
                   (load_day <= load_dim);
  assign accept  = load_valid && load_ok;

  always_comb begin
    cur_inc = cur_q;
    if (cur_q.second != SEC_MAX) begin
      cur_inc.second = cur_q.second + 6'd1;
    end else begin
      cur_inc.second = 6'd0;
      if (cur_q.minute != MIN_MAX) begin
        cur_inc.minute = cur_q.minute + 6'd1;
      end else begin
        cur_inc.minute = 6'd0;
        if (cur_q.hour != HOUR_MAX) begin
          cur_inc.hour = cur_q.hour + 5'd1;
        end else begin
          cur_inc.hour = 5'd0;
          if (cur_q.day < cur_dim) begin
            cur_inc.day = cur_q.day + 5'd1;
          end else begin
            cur_inc.day = 5'd1;
            if (cur_q.month < MONTH_MAX) begin
              cur_inc.month = cur_q.month + 4'd1;
            end else begin
              cur_inc.month = 4'd1;
              cur_inc.year  = cur_q.year + 6'd1;
            end
          end
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (accept) state_d = RUN;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= UNSET;
      presc_q  <= '0;
      cur_q    <= TK_RESET;
      load_err <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cur_q    <= load_t;
        presc_q  <= '0;
        load_err <= 1'b0;
      end else begin
        presc_q <= sec_tick ? '0 : presc_q + PW'(1);
        if (sec_tick)   cur_q    <= cur_inc;
        if (load_valid) load_err <= 1'b1;
      end
    end
  end

  // Shadow samples the pre-update value so same-cycle loads/ticks appear next frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_second <= TK_RESET.second;
      disp_minute <= TK_RESET.minute;
      disp_hour   <= 6'd0;
      disp_month  <= TK_RESET.month;
      disp_day    <= TK_RESET.day;
      disp_year   <= TK_RESET.year;
    end else if (frame_start) begin
      disp_second <= cur_q.second;
      disp_minute <= cur_q.minute;
      disp_hour   <= hand_tick(cur_q.hour, cur_q.minute);
      disp_month  <= cur_q.month;
      disp_day    <= cur_q.day;
      disp_year   <= cur_q.year;
    end
  end

endmodule

// File: tb/tb_time_keeper.sv
// tb/tb_time_keeper.sv - randomized self-checking bench for time_keeper against a calendar model
module tb_time_keeper;

  localparam int CLK_HZ = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load_valid = 1'b0;
  logic [4:0] load_hour = '0;
  logic [5:0] load_minute = '0;
  logic [5:0] load_second = '0;
  logic [3:0] load_month = 4'd1;
  logic [4:0] load_day = 5'd1;
  logic [5:0] load_year = '0;
  logic       frame_start = 1'b0;
  logic       sec_tick;
  logic       time_valid;
  logic       load_err;
  logic [5:0] disp_second;
  logic [5:0] disp_minute;
  logic [5:0] disp_hour;
  logic [3:0] disp_month;
  logic [4:0] disp_day;
  logic [5:0] disp_year;

  time_keeper #(.CLK_HZ(CLK_HZ)) dut (
    .clk         (clk),
    .reset       (reset),
    .load_valid  (load_valid),
    .load_hour   (load_hour),
    .load_minute (load_minute),
    .load_second (load_second),
    .load_month  (load_month),
    .load_day    (load_day),
    .load_year   (load_year),
    .frame_start (frame_start),
    .sec_tick    (sec_tick),
    .time_valid  (time_valid),
    .load_err    (load_err),
    .disp_second (disp_second),
    .disp_minute (disp_minute),
    .disp_hour   (disp_hour),
    .disp_month  (disp_month),
    .disp_day    (disp_day),
    .disp_year   (disp_year)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // model: calendar fields, cycles since last second boundary, status, shadow
  int mh, mm, ms, mmo, md, my, mcnt, mvalid, merr;
  int dsec, dmin, dhr, dmo, dday, dyr;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int dim(input int mo, input int y);
    if (mo == 2) return (y % 4 == 0) ? 29 : 28;
    if (mo == 4 || mo == 6 || mo == 9 || mo == 11) return 30;
    return 31;
  endfunction

  task automatic m_reset();
    mh = 0; mm = 0; ms = 0; mmo = 1; md = 1; my = 0;
    mcnt = 0; mvalid = 0; merr = 0;
    dsec = 0; dmin = 0; dhr = 0; dmo = 1; dday = 1; dyr = 0;
  endtask

  task automatic m_advance();
    int sod;
    sod = mh * 3600 + mm * 60 + ms + 1;
    if (sod == 86400) begin
      sod = 0;
      md++;
      if (md > dim(mmo, my)) begin
        md = 1;
        mmo++;
        if (mmo > 12) begin
          mmo = 1;
          my = (my + 1) % 64;
        end
      end
    end
    mh = sod / 3600;
    mm = (sod / 60) % 60;
    ms = sod % 60;
  endtask

  task automatic m_edge(input bit lv, input bit fs);
    bit tick, ok;
    int lh, lm, ls, lmo, ld, ly;
    lh = load_hour; lm = load_minute; ls = load_second;
    lmo = load_month; ld = load_day; ly = load_year;
    tick = (mcnt == CLK_HZ - 1);
    if (fs) begin
      dsec = ms; dmin = mm; dhr = (mh % 12) * 5 + mm / 12;
      dmo = mmo; dday = md; dyr = my;
    end
    ok = (lh <= 23) && (lm <= 59) && (ls <= 59) && (lmo >= 1) && (lmo <= 12) &&
         (ld >= 1) && (ld <= dim(lmo, ly));
    if (lv && ok) begin
      mh = lh; mm = lm; ms = ls; mmo = lmo; md = ld; my = ly;
      mcnt = 0; merr = 0; mvalid = 1;
    end else begin
      if (lv) merr = 1;
      if (tick) m_advance();
      mcnt = tick ? 0 : mcnt + 1;
    end
  endtask

  task automatic check_all();
    chk("sec_tick", sec_tick, (mcnt == CLK_HZ - 1) ? 1 : 0);
    chk("time_valid", time_valid, mvalid);
    chk("load_err", load_err, merr);
    chk("disp_second", disp_second, dsec);
    chk("disp_minute", disp_minute, dmin);
    chk("disp_hour", disp_hour, dhr);
    chk("disp_month", disp_month, dmo);
    chk("disp_day", disp_day, dday);
    chk("disp_year", disp_year, dyr);
  endtask

  // Called at a falling edge; drives strobes for one cycle and checks outputs before the edge.
  task automatic step(input bit lv, input bit fs);
    load_valid = lv;
    frame_start = fs;
    #1;
    check_all();
    @(posedge clk);
    m_edge(lv, fs);
    @(negedge clk);
    load_valid = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic set_load(input int h, input int m, input int s, input int mo, input int d, input int y);
    load_hour = 5'(h); load_minute = 6'(m); load_second = 6'(s);
    load_month = 4'(mo); load_day = 5'(d); load_year = 6'(y);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  initial begin
    int found;
    int old_sec, old_min;
    m_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // reset state and first tick latency
    chk("rst_disp_second", disp_second, 0);
    chk("rst_disp_hour", disp_hour, 0);
    chk("rst_disp_month", disp_month, 1);
    chk("rst_disp_day", disp_day, 1);
    chk("rst_disp_year", disp_year, 0);
    chk("rst_time_valid", time_valid, 0);
    found = 0;
    for (int k = 1; k <= 10 && found == 0; k++) begin
      #1;
      if (sec_tick) found = k;
      step(1'b0, 1'b0);
    end
    chk("rst_first_tick_cycle", found, 4);

    // rollover across a year
    set_load(23, 59, 58, 12, 31, 7);
    step(1'b1, 1'b0);
    run(2 * CLK_HZ);
    step(1'b0, 1'b1);
    chk("roll_hour", disp_hour, 0);
    chk("roll_minute", disp_minute, 0);
    chk("roll_second", disp_second, 0);
    chk("roll_month", disp_month, 1);
    chk("roll_day", disp_day, 1);
    chk("roll_year", disp_year, 8);
    chk("roll_valid", time_valid, 1);

    // leap and non-leap February
    set_load(23, 59, 59, 2, 28, 8);
    step(1'b1, 1'b0);
    run(CLK_HZ);
    step(1'b0, 1'b1);
    chk("leap_month", disp_month, 2);
    chk("leap_day", disp_day, 29);
    set_load(23, 59, 59, 2, 28, 9);
    step(1'b1, 1'b0);
    run(CLK_HZ);
    step(1'b0, 1'b1);
    chk("noleap_month", disp_month, 3);
    chk("noleap_day", disp_day, 1);
    chk("noleap_year", disp_year, 9);

    // rejected frames
    set_load(10, 60, 0, 5, 5, 5);
    step(1'b1, 1'b0);
    chk("rej_min_err", load_err, 1);
    set_load(1, 2, 3, 2, 30, 8);
    step(1'b1, 1'b0);
    chk("rej_feb30_err", load_err, 1);
    run(CLK_HZ);
    step(1'b0, 1'b1);
    chk("rej_keeps_month", disp_month, 3);
    set_load(12, 0, 0, 6, 1, 10);
    step(1'b1, 1'b0);
    chk("accept_clears_err", load_err, 0);

    // shadow holds across a mid-frame tick; hour-hand tick
    step(1'b0, 1'b1);
    old_min = disp_minute;
    set_load(15, 35, 59, 6, 15, 10);
    step(1'b1, 1'b0);
    run(CLK_HZ);
    chk("shadow_hold_min", disp_minute, old_min);
    step(1'b0, 1'b1);
    chk("shadow_min", disp_minute, 36);
    chk("shadow_hour_tick", disp_hour, 18);
    chk("shadow_sec", disp_second, 0);

    // load + tick + frame in one cycle
    run(2);
    old_sec = ms;
    old_min = mm;
    #1;
    chk("col_tick_present", sec_tick, 1);
    set_load(7, 20, 30, 3, 10, 12);
    step(1'b1, 1'b1);
    chk("col_disp_old_sec", disp_second, old_sec);
    chk("col_disp_old_min", disp_minute, old_min);
    step(1'b0, 1'b1);
    chk("col_new_sec", disp_second, 30);
    chk("col_new_hour_tick", disp_hour, 36);
    chk("col_new_year", disp_year, 12);

    // reset asserted during a full carry
    set_load(23, 59, 59, 12, 31, 63);
    step(1'b1, 1'b0);
    run(CLK_HZ - 1);
    #2;
    reset = 1'b1;
    m_reset();
    #1;
    chk("rstc_tick", sec_tick, 0);
    chk("rstc_valid", time_valid, 0);
    chk("rstc_disp_month", disp_month, 1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    step(1'b0, 1'b1);
    chk("rstc_sec", disp_second, 0);
    chk("rstc_day", disp_day, 1);
    chk("rstc_year", disp_year, 0);

    // randomized frames, many out of range
    for (int i = 0; i < 1500; i++) begin
      bit lv;
      lv = ($urandom_range(0, 7) == 0);
      if (lv) begin
        if ($urandom_range(0, 3) == 0)
          set_load($urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63),
                   $urandom_range(0, 15), $urandom_range(0, 31), $urandom_range(0, 63));
        else
          set_load($urandom_range(22, 23), $urandom_range(58, 59), $urandom_range(57, 59),
                   $urandom_range(1, 12), $urandom_range(27, 31), $urandom_range(0, 63));
      end
      step(lv, (i % 10) == 9);
    end
    #1;
    check_all();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
